// File: rtl/amem_rd_pkg.sv
// amem_rd_pkg
//   Shared definitions for the analog memory readout controller:
//   FSM state encoding, out_data field layout helpers and the timestamp width.
//   Optional macro: AMEM_RD_TIMESTAMP_EN widens out_data by TS_W bits
//   ({ts, err, addr, meta, adc}); undefined gives {err, addr, meta, adc}.
package amem_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CONV   = 3'd2,
    ST_OUT    = 3'd3,
    ST_CLR    = 3'd4
  } rd_state_e;

  localparam int TS_W       = 16;
  localparam int CNT_W      = 8;
  localparam int OD_ADC_LSB = 0;

  // out_data field offsets, derived from the per-instance field widths
  function automatic int od_meta_lsb(input int adc_w);
    return adc_w;
  endfunction

  function automatic int od_addr_lsb(input int adc_w, input int meta_w);
    return adc_w + meta_w;
  endfunction

  function automatic int od_err_lsb(input int adc_w, input int meta_w, input int addr_w);
    return adc_w + meta_w + addr_w;
  endfunction

  function automatic int od_ts_lsb(input int adc_w, input int meta_w, input int addr_w);
    return adc_w + meta_w + addr_w + 1;
  endfunction

  function automatic int od_width(input int adc_w, input int meta_w, input int addr_w);
`ifdef AMEM_RD_TIMESTAMP_EN
    return od_ts_lsb(adc_w, meta_w, addr_w) + TS_W;
`else
    return od_ts_lsb(adc_w, meta_w, addr_w);
`endif
  endfunction

endpackage

// File: rtl/amem_rr_pick.sv
// amem_rr_pick
//   Combinational round-robin priority picker. Searches req starting at
//   ptr+1 and wrapping modulo NCELLS; returns the first requesting index.
//   Ports: req[NCELLS] request flags, ptr[ADDR_W] last served index,
//          hit = any request, idx[ADDR_W] selected index (0 when !hit).
module amem_rr_pick #(
  parameter int NCELLS = 8,
  parameter int ADDR_W = 3
) (
  input  logic [NCELLS-1:0] req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              hit,
  output logic [ADDR_W-1:0] idx
);

  logic [ADDR_W-1:0] cand_s;

  // offset 1 is checked first, so the last served index has lowest priority
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int i = 1; i <= NCELLS; i++) begin
      cand_s = ADDR_W'((int'(ptr) + i) % NCELLS);
      if (!hit && req[cand_s]) begin
        hit = 1'b1;
        idx = cand_s;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/amem_readout_ctrl.sv
// amem_readout_ctrl
//   Read-side controller for the analog memory core. Picks one occupied cell
//   at a time (round robin), closes its column switch, waits for settling,
//   triggers the column ADC, captures result plus stored metadata, presents
//   it on a valid/ready stream and finally pulses the cell's clear line.
//   Ports:
//     clk, resetb (async active-low)   enable (sampled in IDLE only)
//     cell_full/cell_meta              occupancy and metadata from the core
//     rd_addr/rd_en                    selected cell and column switch
//     adc_start/adc_done/adc_data      column ADC handshake
//     cell_clr                         one-hot one-cycle cell reset
//     out_valid/out_ready/out_data     output stream {[ts,] err, addr, meta, adc}
//     busy, tmo_err                    status (tmo_err sticky until reset)
//   Optional macro: AMEM_RD_TIMESTAMP_EN adds a free-running 16-bit timestamp
//   captured with each conversion result.
module amem_readout_ctrl
  import amem_rd_pkg::*;
#(
  parameter int NCELLS     = 8,
  parameter int ADDR_W     = 3,
  parameter int ADC_W      = 10,
  parameter int META_W     = 8,
  parameter int SETTLE_CYC = 4,
  parameter int ADC_TMO    = 63
) (
  input  logic                                      clk,
  input  logic                                      resetb,
  input  logic                                      enable,
  input  logic [NCELLS-1:0]                         cell_full,
  input  logic [NCELLS*META_W-1:0]                  cell_meta,
  output logic [ADDR_W-1:0]                         rd_addr,
  output logic                                      rd_en,
  output logic                                      adc_start,
  input  logic                                      adc_done,
  input  logic [ADC_W-1:0]                          adc_data,
  output logic [NCELLS-1:0]                         cell_clr,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [od_width(ADC_W, META_W, ADDR_W)-1:0] out_data,
  output logic                                      busy,
  output logic                                      tmo_err
);

  localparam int OUT_W    = od_width(ADC_W, META_W, ADDR_W);
  localparam int META_LSB = od_meta_lsb(ADC_W);
  localparam int ADDR_LSB = od_addr_lsb(ADC_W, META_W);
  localparam int ERR_LSB  = od_err_lsb(ADC_W, META_W, ADDR_W);

  rd_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               rd_en_q, rd_en_d;
  logic               adc_start_q, adc_start_d;
  logic [NCELLS-1:0]  cell_clr_q, cell_clr_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               busy_q, busy_d;
  logic               tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_hit_s;
  logic [ADDR_W-1:0]  pick_idx_s;
  logic [META_W-1:0]  meta_sel_s;
  logic               cap_en_s;
  logic               cap_err_s;
  logic [ADC_W-1:0]   cap_adc_s;

`ifdef AMEM_RD_TIMESTAMP_EN
  localparam int TS_LSB = od_ts_lsb(ADC_W, META_W, ADDR_W);
  logic [TS_W-1:0]    ts_q, ts_d;
`endif

  amem_rr_pick #(
    .NCELLS (NCELLS),
    .ADDR_W (ADDR_W)
  ) u_pick (
    .req (cell_full),
    .ptr (rr_ptr_q),
    .hit (pick_hit_s),
    .idx (pick_idx_s)
  );

  // metadata mux driven by the registered address, never by the picker
  always_comb begin
    meta_sel_s = '0;
    for (int i = 0; i < NCELLS; i++) begin
      if (rd_addr_q == ADDR_W'(i)) begin
        meta_sel_s = cell_meta[i*META_W +: META_W];
      end else begin
        meta_sel_s = meta_sel_s;
      end
    end
  end

  // next-state and output logic of the readout sequencer
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = rd_en_q;
    adc_start_d = 1'b0;
    cell_clr_d  = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    tmo_err_d   = tmo_err_q;
    cnt_d       = cnt_q;
    cap_en_s    = 1'b0;
    cap_err_s   = 1'b0;
    cap_adc_s   = '0;

    case (state_q)
      ST_IDLE: begin
        if (enable && pick_hit_s) begin
          rd_addr_d = pick_idx_s;
          rd_en_d   = 1'b1;
          cnt_d     = CNT_W'(SETTLE_CYC - 1);
          state_d   = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        // adc_start is registered, so it appears SETTLE_CYC cycles after rd_en
        if (cnt_q == '0) begin
          adc_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_CONV;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_CONV: begin
        cnt_d = cnt_q + CNT_W'(1);
        // done is checked first so a result on the timeout cycle still wins
        if (adc_done) begin
          cap_en_s  = 1'b1;
          cap_err_s = 1'b0;
          cap_adc_s = adc_data;
          state_d   = ST_OUT;
        end else if ((cnt_q + CNT_W'(1)) == CNT_W'(ADC_TMO)) begin
          cap_en_s  = 1'b1;
          cap_err_s = 1'b1;
          cap_adc_s = '0;
          tmo_err_d = 1'b1;
          state_d   = ST_OUT;
        end else begin
          state_d = ST_CONV;
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rd_en_d     = 1'b0;
          cell_clr_d  = NCELLS'(1) << rd_addr_q;
          rr_ptr_d    = rd_addr_q;
          state_d     = ST_CLR;
        end else begin
          state_d = ST_OUT;
        end
      end

      ST_CLR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        rd_en_d     = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase

    if (cap_en_s) begin
      out_valid_d                          = 1'b1;
      out_data_d                           = '0;
      out_data_d[OD_ADC_LSB +: ADC_W]      = cap_adc_s;
      out_data_d[META_LSB +: META_W]       = meta_sel_s;
      out_data_d[ADDR_LSB +: ADDR_W]       = rd_addr_q;
      out_data_d[ERR_LSB]                  = cap_err_s;
`ifdef AMEM_RD_TIMESTAMP_EN
      out_data_d[TS_LSB +: TS_W]           = ts_q;
`endif
    end else begin
      out_data_d = out_data_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

`ifdef AMEM_RD_TIMESTAMP_EN
  // free-running timestamp, wraps naturally from 0xFFFF to 0x0000
  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  // timestamp register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end
`endif

  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ADDR_W'(NCELLS - 1);
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      adc_start_q <= 1'b0;
      cell_clr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      adc_start_q <= adc_start_d;
      cell_clr_q  <= cell_clr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      tmo_err_q   <= tmo_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign rd_en     = rd_en_q;
  assign adc_start = adc_start_q;
  assign cell_clr  = cell_clr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_amem_readout_ctrl.sv
// tb_amem_readout_ctrl
//   Scoreboard bench: each directed read pushes its expected output word and
//   expected cell_clr pattern; monitors pop and compare on the DUT handshake
//   and on each cell_clr pulse. A small cell model clears cell_full bits on
//   cell_clr, and an ADC model answers adc_start after a set latency.
module tb_amem_readout_ctrl;
  import amem_rd_pkg::*;

  localparam int NCELLS     = 8;
  localparam int ADDR_W     = 3;
  localparam int ADC_W      = 10;
  localparam int META_W     = 8;
  localparam int SETTLE_CYC = 4;
  localparam int ADC_TMO    = 63;
  localparam int BASE_W     = 1 + ADDR_W + META_W + ADC_W;
`ifdef AMEM_RD_TIMESTAMP_EN
  localparam int OUT_W = BASE_W + TS_W;
`else
  localparam int OUT_W = BASE_W;
`endif

  logic                       clk = 1'b0;
  logic                       resetb;
  logic                       enable;
  logic [NCELLS-1:0]          cell_full;
  logic [NCELLS*META_W-1:0]   cell_meta;
  logic [ADDR_W-1:0]          rd_addr;
  logic                       rd_en;
  logic                       adc_start;
  logic                       adc_done;
  logic [ADC_W-1:0]           adc_data;
  logic [NCELLS-1:0]          cell_clr;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_data;
  logic                       busy;
  logic                       tmo_err;

  amem_readout_ctrl #(
    .NCELLS(NCELLS), .ADDR_W(ADDR_W), .ADC_W(ADC_W), .META_W(META_W),
    .SETTLE_CYC(SETTLE_CYC), .ADC_TMO(ADC_TMO)
  ) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .cell_full(cell_full),
    .cell_meta(cell_meta), .rd_addr(rd_addr), .rd_en(rd_en),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .cell_clr(cell_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [BASE_W-1:0] exp_q[$];
  logic [NCELLS-1:0] clr_q[$];
  int                done_q[$];

  bit             hold_full = 1'b0;
  bit             adc_never = 1'b0;
  int             adc_lat   = 3;
  logic [ADC_W-1:0] adc_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // expected word for a read of cell a; metadata of cell i is 8'hA0+i
  task automatic push(input logic err, input logic [ADDR_W-1:0] a, input logic [ADC_W-1:0] adc);
    exp_q.push_back({err, a, 8'hA0 + {5'd0, a}, adc});
    clr_q.push_back(NCELLS'(1) << a);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_rd_addr"},   64'(rd_addr),   64'd0);
    chk({tag, "_rd_en"},     64'(rd_en),     64'd0);
    chk({tag, "_adc_start"}, 64'(adc_start), 64'd0);
    chk({tag, "_cell_clr"},  64'(cell_clr),  64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_tmo_err"},   64'(tmo_err),   64'd0);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || clr_q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size() == 0 && clr_q.size() == 0 && !busy), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // ADC model: answers each adc_start with one adc_done pulse after adc_lat cycles
  initial begin
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc_start === 1'b1 && !adc_never) begin
        repeat (adc_lat) @(posedge clk);
        #1;
        adc_done = 1'b1;
        adc_data = adc_val;
        done_q.push_back(cyc);
        @(posedge clk);
        #1;
        adc_done = 1'b0;
        adc_data = '0;
      end
    end
  end

  bit   hs_prev = 1'b0;
  bit   rd_en_prev = 1'b0;
  bit   pend = 1'b0;
  int   t_rise = 0;
  int   starts = 0;
  logic [BASE_W-1:0] e;
`ifdef AMEM_RD_TIMESTAMP_EN
  bit              have_prev = 1'b0;
  logic [TS_W-1:0] prev_ts, cur_ts;
  int              prev_dc, dc;
`endif

  // monitors: output scoreboard, cell_clr scoreboard, settle timing, cell model
  always @(negedge clk) begin
    if (resetb) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got 0x%0h expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data[BASE_W-1:0]), 64'(e));
`ifdef AMEM_RD_TIMESTAMP_EN
          if (e[BASE_W-1] == 1'b0 && done_q.size() > 0) begin
            dc     = done_q.pop_front();
            cur_ts = out_data[OUT_W-1 -: TS_W];
            if (have_prev) chk("ts_delta", 64'(cur_ts - prev_ts), 64'(16'(dc - prev_dc)));
            prev_ts   = cur_ts;
            prev_dc   = dc;
            have_prev = 1'b1;
          end
`endif
        end
      end
      if (cell_clr != '0) begin
        chk("clr_after_handshake", 64'(hs_prev), 64'd1);
        if (clr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cell_clr_unexpected: got 0x%0h expected 0x0", cell_clr);
        end else begin
          chk("cell_clr", 64'(cell_clr), 64'(clr_q.pop_front()));
        end
      end
      if (rd_en && !rd_en_prev) begin
        t_rise = cyc;
        pend   = 1'b1;
        starts++;
      end
      if (adc_start && pend) begin
        chk("settle_delay", 64'(cyc - t_rise), 64'(SETTLE_CYC));
        pend = 1'b0;
      end
      hs_prev    = out_valid && out_ready;
      rd_en_prev = rd_en;
      if (!hold_full) cell_full = cell_full & ~cell_clr;
    end else begin
      hs_prev    = 1'b0;
      rd_en_prev = 1'b0;
      pend       = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n, t0;
    resetb    = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b1;
    cell_full = '0;
    for (int i = 0; i < NCELLS; i++) cell_meta[i*META_W +: META_W] = 8'hA0 + 8'(i);
    #3;
    resetb = 1'b0;
    #1;
    check_reset_outs("reset");
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;

    // single cell 2, ADC answers 3 cycles after adc_start
    adc_lat = 3;
    adc_val = 10'h2A5;
    exp_q.push_back({1'b0, 3'd2, 8'hA2, 10'h2A5});
    clr_q.push_back(8'b0000_0100);
    cell_full = 8'b0000_0100;
    enable    = 1'b1;
    wait_drain("single_drain", 100);
    chk("single_idle", 64'(busy), 64'd0);

    // fresh reset so the round robin starts at cell 0
    resetb = 1'b0;
    #1;
    check_reset_outs("reset2");
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;

    // round robin with every cell full and held full
    hold_full = 1'b1;
    adc_val   = 10'h155;
    for (int i = 0; i < NCELLS; i++) push(1'b0, 3'(i), 10'h155);
    push(1'b0, 3'd0, 10'h155);
    s0 = starts;
    cell_full = 8'hFF;
    n = 0;
    while (starts < s0 + 9 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rr_starts", 64'(starts - s0), 64'd9);
    enable = 1'b0;
    wait_drain("rr_drain", 100);
    hold_full = 1'b0;
    cell_full = '0;
    enable    = 1'b1;

    // backpressure on cell 4 for 20 cycles
    out_ready = 1'b0;
    adc_val   = 10'h3C3;
    push(1'b0, 3'd4, 10'h3C3);
    cell_full = 8'h10;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data[BASE_W-1:0]), 64'({1'b0, 3'd4, 8'hA4, 10'h3C3}));
      chk("bp_no_clr", 64'(cell_clr), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("bp_drain", 50);

    // timeout on cell 6
    adc_never = 1'b1;
    push(1'b1, 3'd6, 10'h000);
    cell_full = 8'h40;
    n = 0;
    while (!adc_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    n = 0;
    while (!out_valid && n < 150) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 64'(cyc - t0), 64'(ADC_TMO));
    wait_drain("tmo_drain", 50);
    chk("tmo_err_set", 64'(tmo_err), 64'd1);
    adc_never = 1'b0;

    // good conversion after a timeout keeps tmo_err sticky
    adc_val = 10'h0F0;
    push(1'b0, 3'd1, 10'h0F0);
    cell_full = 8'h02;
    wait_drain("good_drain", 100);
    chk("tmo_err_sticky", 64'(tmo_err), 64'd1);

    // adc_done on the final timeout cycle still counts as success
    adc_lat = ADC_TMO - 1;
    adc_val = 10'h2AA;
    push(1'b0, 3'd5, 10'h2AA);
    cell_full = 8'h20;
    wait_drain("edge_drain", 200);
    adc_lat = 3;

    // reset in the middle of a conversion on cell 3
    adc_never = 1'b1;
    cell_full = 8'h08;
    n = 0;
    while (!adc_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b0;
    #1;
    check_reset_outs("midreset");
    repeat (2) @(negedge clk);
    resetb    = 1'b1;
    adc_never = 1'b0;
    adc_val   = 10'h111;
    push(1'b0, 3'd0, 10'h111);
    push(1'b0, 3'd3, 10'h111);
    cell_full = 8'h09;
    wait_drain("post_reset_drain", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amem_readout_ctrl.md
Name: amem_readout_ctrl

Overview:
Read-side controller for the analog memory core. Scans the per-cell full flags and selects one occupied cell at a time. For each cell it waits for the sampling capacitor to settle, triggers the column ADC, and captures the conversion with the cell's stored metadata. It then presents the word on a valid/ready stream and clears the cell so the write side can reuse it.

Parameters:
NCELLS, 8, number of analog memory cells
ADDR_W, 3, cell address width, equal to clog2(NCELLS)
ADC_W, 10, ADC result width
META_W, 8, metadata width per cell
SETTLE_CYC, 4, clk cycles from rd_en rising to adc_start (1..15)
ADC_TMO, 63, max cycles to wait for adc_done after adc_start (1..255)

Ports:
clk  in  1  system clock
resetb  in  1  asynchronous active-low reset
enable  in  1  readout enable; sampled only in IDLE
cell_full  in  NCELLS  occupancy flag per cell, from amem_core
cell_meta  in  NCELLS*META_W  stored metadata, cell i at bits [i*META_W +: META_W]
rd_addr  out  ADDR_W  selected cell address
rd_en  out  1  cell-to-column switch enable
adc_start  out  1  one-cycle ADC convert pulse
adc_done  in  1  one-cycle conversion-complete pulse
adc_data  in  ADC_W  conversion result, valid when adc_done=1
cell_clr  out  NCELLS  one-hot one-cycle per-cell reset pulse
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  1+ADDR_W+META_W+ADC_W  word packed as {err, addr, meta, adc}
busy  out  1  high in every state except IDLE
tmo_err  out  1  sticky: set on any ADC timeout, cleared only by reset

Behaviour:
- Reset (resetb=0, asynchronous): state IDLE; rr_ptr=NCELLS-1; all outputs 0; out_data=0; tmo_err=0. Reset asserted mid-operation aborts the transfer and issues no cell_clr pulse.
- IDLE:
  - If enable=1 and |cell_full, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... with wrap modulo NCELLS.
  - Register that index into rd_addr, set rd_en=1, load the settle counter, and go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE: count down SETTLE_CYC cycles. adc_start pulses in the last SETTLE cycle, so adc_start is high exactly SETTLE_CYC cycles after the IDLE→SETTLE edge. Then go to CONV with the timeout counter cleared.
- CONV: timeout counter increments every cycle.
  - adc_done=1: capture adc_data and cell_meta[rd_addr]; err=0; go to OUT.
  - Counter reaches ADC_TMO without adc_done: adc=0, err=1, set tmo_err, go to OUT.
  - adc_done arriving in the same cycle the counter reaches ADC_TMO counts as success.
  - adc_done outside CONV is ignored.
- OUT:
  - out_valid=1 and out_data are held stable until out_ready=1; once asserted, out_valid does not drop without a handshake.
  - On handshake: out_valid=0, rd_en=0, cell_clr[rd_addr]=1 for exactly one cycle, rr_ptr=rd_addr, go to CLR.
- CLR: one cycle for cell_clr to propagate; return to IDLE. cell_full of the cleared cell is not sampled in this cycle.
- Minimum per-cell cost: 1 + SETTLE_CYC + adc latency + 1 + 1 cycles.
- Round-robin: after servicing cell k, the next search starts at k+1, so all full cells are served before k repeats.
- Dropping enable outside IDLE does not abort; the current cell completes.
- A cell_full bit dropping while its cell is selected is ignored; the cell is still read and cleared.
- The meta capture uses the registered rd_addr, never a combinational pick.

Optional Feature:
AMEM_RD_TIMESTAMP_EN:
- Defined: adds a free-running 16-bit counter (reset 0, wraps at 0xFFFF). Its value is captured on the same cycle as the adc_done capture, or the timeout capture. out_data becomes {ts[15:0], err, addr, meta, adc}, widening the port by 16.
- Undefined: no counter exists and out_data has the base width.

Decomposition:
- Shared package amem_rd_pkg:
  - state encoding constants: IDLE=0, SETTLE=1, CONV=2, OUT=3, CLR=4
  - out_data field offsets and widths
  - TS_W=16
- One sub-module, amem_rr_pick: combinational round-robin priority picker with inputs (req[NCELLS], ptr[ADDR_W]) and outputs (hit, idx[ADDR_W]). It is reused by the future multi-column readout.

Test Plan:
- Single cell: cell_full=8'b0000_0100, enable=1, ADC returns 0x2A5 three cycles after adc_start → adc_start exactly 4 cycles after rd_en rises; out_data={0,3'd2,meta[2],10'h2A5}; cell_clr=8'b0000_0100 for one cycle; back in IDLE.
- Round-robin: cell_full=8'hFF held, out_ready=1 → addresses served in order 0,1,...,7,0; no cell served twice before all 8 are served.
- Backpressure: out_ready=0 for 20 cycles during OUT → out_valid and out_data are stable every cycle; no cell_clr until the cycle after out_ready=1.
- Timeout: ADC never pulses adc_done → after 63 CONV cycles out_data err=1 and adc=0; tmo_err=1 and stays set across later good conversions.
- Reset mid-CONV: resetb low for 2 cycles → all outputs 0 immediately; no cell_clr pulse; the next readout after reset starts at cell 0.
- Timestamp (AMEM_RD_TIMESTAMP_EN defined): two reads with known adc_done spacing → the ts difference equals the cycle difference; force wrap at 0xFFFF → ts=0x0000.
